jk_pattern_driver: RTL and testbench
====================================

# jk_pattern_driver

Drives a bank of WIDTH external JK flip-flops to a requested target word. For each bit it computes the J/K excitation from the bank's current Q readback, applies it for exactly one clock, and then checks the readback against the target. Where the JK flip-flop turns J/K into a next state, this block works the other way: it turns a desired next state back into J/K. It sits between a valid/ready command source and the JK register bank.

## Interface
Parameters:
- WIDTH, 4, number of JK flip-flops driven.
- TOGGLE_EN, 1, 1: a flipping bit uses J=K=1; 0: a flipping bit uses set (J=1,K=0) or reset (J=0,K=1).
- RETRIES, 1, extra drive attempts after a failed check, range 0..7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- tgt_valid  in  1  target word offered.
- tgt_data  in  WIDTH  target Q pattern.
- tgt_ready  out  1  block can accept a target; high only in IDLE.
- j  out  WIDTH  J inputs to the bank, registered.
- k  out  WIDTH  K inputs to the bank, registered.
- q_in  in  WIDTH  Q readback from the bank, sampled synchronously.
- busy  out  1  high in DRIVE or CHECK.
- done  out  1  one-cycle pulse when a command completes (pass or fail).
- err  out  1  qualifies done: the final check mismatched.
- err_mask  out  WIDTH  q_in XOR target from the final check; held until the next done.

## Operation
- FSM states: IDLE, DRIVE, CHECK.
- IDLE → DRIVE on tgt_valid && tgt_ready.
  - Capture tgt_data into tgt_q.
  - Load j/k from the excitation of (q_in, tgt_data).
  - Clear the attempt counter.
- DRIVE → CHECK unconditionally. j/k are cleared to 0 at this edge, so the bank sees nonzero J/K for exactly one cycle.
- CHECK, on the edge that samples q_in:
  - If q_in == tgt_q: go to IDLE, done=1, err=0, err_mask=0.
  - If they differ and attempts < RETRIES: increment attempts, go to DRIVE, reload j/k from the excitation of (q_in, tgt_q).
  - If they differ and attempts == RETRIES: go to IDLE, done=1, err=1, err_mask=q_in^tgt_q.
- Per-bit excitation for current q and target t:
  - q==t: J=0, K=0 (hold).
  - q≠t and TOGGLE_EN=1: J=1, K=1.
  - q≠t and TOGGLE_EN=0: J=t, K=~t.
- A target equal to the current Q still runs one DRIVE/CHECK pass with J=K=0.
- tgt_data is ignored outside IDLE. No queueing.

## Timing
- Reset values: state=IDLE, j=0, k=0, done=0, err=0, err_mask=0, busy=0, attempts=0.
- tgt_ready is decoded combinationally from state, so it is 1 as soon as reset is released.
- Edge numbering for an accepted command:
  - E0: accept.
  - j/k valid in the cycle after E0.
  - E1: bank updates and the FSM enters CHECK.
  - E2: compare.
  - done is high in the cycle after E2.
- Pass case: accept-to-done latency is 2 edges.
- Each retry adds 2 edges.
- With tgt_valid held high, back-to-back accepts are 3 cycles apart when no retries occur.
- done and err are registered and last exactly one cycle.
- rst_n asserted in any state aborts the command immediately and asynchronously. j/k return to 0 and no done is issued.
- attempts is a 3-bit counter. It is only compared against RETRIES and never wraps.

## Structure
- Shared package jk_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK);
  - localparam encodings for excitation pairs: HOLD=2'b00, RST=2'b01, SET=2'b10, TOG=2'b11.
- Sub-module jk_excite: combinational, parameterised by WIDTH and TOGGLE_EN. Inputs q, t; outputs j, k. It is instantiated once, and its inputs are multiplexed between tgt_data (accept) and tgt_q (retry).
- The bench includes a behavioural WIDTH-bit JK bank with a per-bit stuck-at-0 override.

## Test plan
- Reset mid-DRIVE (j=1010): rst_n low → j=k=0000, busy=0, done=0 with no clock edge; after release, tgt_ready=1.
- TOGGLE_EN=1, bank q=0000, target 1010 → j=k=1010 for one cycle, q=1010 after E1, done=1 and err=0 in the cycle after E2.
- TOGGLE_EN=0, bank q=1100, target 1010 → j=0010, k=0100 for one cycle; done=1, err=0, q=1010.
- Bank q=0110, target 0110 → j=k=0000 throughout, done=1, err=0, err_mask=0000.
- RETRIES=1, bank bit0 stuck at 0, q=0000, target 0001 → two DRIVE cycles each with j[0]=k[0]=1; done=1, err=1, err_mask=0001 four edges after accept.
- tgt_valid held high with targets 0011 then 1100 from q=0000 → accepts 3 cycles apart, two done pulses, final q=1100, tgt_ready low during busy.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types for the JK pattern driver:
// FSM states and J/K excitation pair encodings.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } state_t;

    // {J,K} pairs
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TOG  = 2'b11;

endpackage

// File: rtl/jk_pattern_driver_if.sv
// Target command handshake between the command
// source (master) and the pattern driver (slave).
interface jk_pattern_driver_if #(
    parameter int WIDTH = 4
);

    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;

    modport master (
        output tgt_valid,
        output tgt_data,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_data,
        output tgt_ready
    );

endinterface

// File: rtl/jk_excite.sv
// Inverse JK table: turns current Q and desired
// next Q into the J/K pair that produces it.
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit TOGGLE_EN = 1'b1
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (1'b1)
                (q[i] == t[i]):
                    {j[i], k[i]} = HOLD;
                (q[i] != t[i]) && TOGGLE_EN:
                    {j[i], k[i]} = TOG;
                (q[i] != t[i]) && !TOGGLE_EN && t[i]:
                    {j[i], k[i]} = SET;
                default:
                    {j[i], k[i]} = RST;
            endcase
        end
    end

endmodule

// File: rtl/jk_pattern_driver.sv
// Drives an external JK bank to a target word,
// pulsing J/K for one cycle and verifying readback.
module jk_pattern_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit TOGGLE_EN = 1'b1,
    parameter int RETRIES   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_pattern_driver_if.slave tgt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);

    localparam logic [2:0] RETRY_MAX = 3'(RETRIES);

    state_t           state;
    logic [WIDTH-1:0] tgt_q;
    logic [2:0]       attempts;
    logic [WIDTH-1:0] ex_t;
    logic [WIDTH-1:0] ex_j;
    logic [WIDTH-1:0] ex_k;

    // Accept uses the fresh target, retries the latched one
    assign ex_t = (state == IDLE) ? tgt.tgt_data : tgt_q;

    assign tgt.tgt_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    jk_excite #(
        .WIDTH     (WIDTH),
        .TOGGLE_EN (TOGGLE_EN)
    ) u_excite (
        .q (q_in),
        .t (ex_t),
        .j (ex_j),
        .k (ex_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tgt_q    <= '0;
            attempts <= '0;
            j        <= '0;
            k        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_mask <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tgt.tgt_valid) begin
                        tgt_q    <= tgt.tgt_data;
                        j        <= ex_j;
                        k        <= ex_k;
                        attempts <= '0;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_in == tgt_q) begin
                        done     <= 1'b1;
                        err_mask <= '0;
                        state    <= IDLE;
                    end else if (attempts < RETRY_MAX) begin
                        attempts <= attempts + 3'd1;
                        j        <= ex_j;
                        k        <= ex_k;
                        state    <= DRIVE;
                    end else begin
                        done     <= 1'b1;
                        err      <= 1'b1;
                        err_mask <= q_in ^ tgt_q;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Self-checking bench: toggle-mode and set/reset-mode
// drivers run in lockstep against behavioural JK banks.
module tb_jk_pattern_driver;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jk_pattern_driver_if #(.WIDTH(W)) ifa ();
    jk_pattern_driver_if #(.WIDTH(W)) ifb ();

    assign ifb.tgt_valid = ifa.tgt_valid;
    assign ifb.tgt_data  = ifa.tgt_data;

    logic [W-1:0] ja, ka, jb, kb, qa, qb, ma, mb;
    logic         busya, busyb, donea, doneb, erra, errb;
    logic         ld;
    logic [W-1:0] ld_val, stuck;

    int checks = 0;
    int errors = 0;

    jk_pattern_driver #(
        .WIDTH(W), .TOGGLE_EN(1'b1), .RETRIES(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .tgt(ifa),
        .j(ja), .k(ka), .q_in(qa),
        .busy(busya), .done(donea),
        .err(erra), .err_mask(ma)
    );

    jk_pattern_driver #(
        .WIDTH(W), .TOGGLE_EN(1'b0), .RETRIES(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .tgt(ifb),
        .j(jb), .k(kb), .q_in(qb),
        .busy(busyb), .done(doneb),
        .err(errb), .err_mask(mb)
    );

    function automatic logic [W-1:0] jk_next(
        input logic [W-1:0] q, jj, kk, s
    );
        logic [W-1:0] n;
        for (int i = 0; i < W; i++) begin
            case ({jj[i], kk[i]})
                2'b00:   n[i] = q[i];
                2'b01:   n[i] = 1'b0;
                2'b10:   n[i] = 1'b1;
                default: n[i] = ~q[i];
            endcase
        end
        return n & ~s;
    endfunction

    always_ff @(posedge clk) begin
        qa <= ld ? (ld_val & ~stuck) : jk_next(qa, ja, ka, stuck);
        qb <= ld ? (ld_val & ~stuck) : jk_next(qb, jb, kb, stuck);
    end

    typedef struct {
        logic [W-1:0] q0, t, s;
        logic [W-1:0] jt, kt, js, ks;
        logic [W-1:0] q_end, mask;
        logic         e;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic load_bank(input logic [W-1:0] v,
                             input logic [W-1:0] s);
        @(posedge clk); #1;
        ld = 1'b1; ld_val = v; stuck = s;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    task automatic accept(input logic [W-1:0] t);
        ifa.tgt_valid = 1'b1;
        ifa.tgt_data  = t;
        @(posedge clk); #1;
        ifa.tgt_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  got;
        load_bank(v.q0, v.s);
        accept(v.t);
        chk($sformatf("v%0d_ja", idx), ja, v.jt);
        chk($sformatf("v%0d_ka", idx), ka, v.kt);
        chk($sformatf("v%0d_jb", idx), jb, v.js);
        chk($sformatf("v%0d_kb", idx), kb, v.ks);
        chk($sformatf("v%0d_busy", idx), busya, 1);
        chk($sformatf("v%0d_rdy", idx), ifa.tgt_ready, 0);
        n = 0;
        got = 0;
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (n == 1)
                chk($sformatf("v%0d_jclr", idx),
                    {ja, ka, jb, kb}, 0);
            if (donea) got = 1;
        end
        if (!got) begin
            chk($sformatf("v%0d_timeout", idx), 0, 1);
        end else begin
            chk($sformatf("v%0d_lat", idx), n, v.e ? 4 : 2);
            chk($sformatf("v%0d_doneb", idx), doneb, 1);
            chk($sformatf("v%0d_erra", idx), erra, v.e);
            chk($sformatf("v%0d_errb", idx), errb, v.e);
            chk($sformatf("v%0d_ma", idx), ma, v.mask);
            chk($sformatf("v%0d_mb", idx), mb, v.mask);
            chk($sformatf("v%0d_qa", idx), qa, v.q_end);
            chk($sformatf("v%0d_qb", idx), qb, v.q_end);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse", idx), {donea, erra}, 0);
    endtask

    initial begin
        int nacc, dones, donesb, ovl, c;
        int acc [2];
        bit pend, seen;

        ifa.tgt_valid = 1'b0;
        ifa.tgt_data  = '0;
        ld = 1'b1; ld_val = '0; stuck = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_j", {ja, ka, jb, kb}, 0);
        chk("rst_flags", {busya, donea, erra}, 0);
        chk("rst_mask", ma, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", ifa.tgt_ready, 1);
        ld = 1'b0;

        //          q0      t       s       jt      kt      js      ks      q_end   mask    e
        vt[0] = '{4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b0};
        vt[1] = '{4'b1100, 4'b1010, 4'b0000, 4'b0110, 4'b0110, 4'b0010, 4'b0100, 4'b1010, 4'b0000, 1'b0};
        vt[2] = '{4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 1'b0};
        vt[3] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0};
        vt[4] = '{4'b0101, 4'b1001, 4'b1000, 4'b1100, 4'b1100, 4'b1000, 4'b0100, 4'b0001, 4'b1000, 1'b1};

        for (int i = 0; i < 5; i++) run_vec(vt[i], i);

        // reset while in DRIVE
        load_bank(4'b0000, 4'b0000);
        accept(4'b1010);
        chk("ra_j", ja, 4'b1010);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_jk", {ja, ka, jb, kb}, 0);
        chk("ra_busy", {busya, busyb}, 0);
        chk("ra_done", {donea, doneb}, 0);
        #1 rst_n = 1'b1;
        #1;
        chk("ra_rdy", ifa.tgt_ready, 1);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (donea || doneb) seen = 1;
        end
        chk("ra_nodone", seen, 0);
        chk("ra_q", qa, 4'b0000);

        // stuck bit with one retry
        load_bank(4'b0000, 4'b0001);
        accept(4'b0001);
        chk("st_jk1", {ja, ka, jb, kb}, 16'h1110);
        @(posedge clk); #1;
        chk("st_clr1", {ja, ka}, 0);
        @(posedge clk); #1;
        chk("st_jk2", {ja, ka, jb, kb}, 16'h1110);
        chk("st_busy", {busya, donea}, 2'b10);
        @(posedge clk); #1;
        chk("st_clr2", {ja, ka}, 0);
        @(posedge clk); #1;
        chk("st_done", {donea, erra, doneb, errb}, 4'hf);
        chk("st_mask", {ma, mb}, 8'h11);

        // back-to-back with tgt_valid held high
        load_bank(4'b0000, 4'b0000);
        ifa.tgt_valid = 1'b1;
        ifa.tgt_data  = 4'b0011;
        nacc = 0; dones = 0; donesb = 0; ovl = 0;
        pend = 0; acc[0] = 0; acc[1] = 0;
        for (c = 0; c < 14; c++) begin
            @(negedge clk);
            if (pend) begin
                if (nacc == 1) ifa.tgt_data = 4'b1100;
                else ifa.tgt_valid = 1'b0;
                pend = 0;
            end
            if (donea) dones++;
            if (doneb) donesb++;
            if (busya && ifa.tgt_ready) ovl++;
            if (ifa.tgt_valid && ifa.tgt_ready) begin
                if (nacc < 2) acc[nacc] = c;
                nacc++;
                pend = 1;
            end
        end
        chk("bb_nacc", nacc, 2);
        chk("bb_gap", acc[1] - acc[0], 3);
        chk("bb_dones", dones, 2);
        chk("bb_donesb", donesb, 2);
        chk("bb_ovl", ovl, 0);
        chk("bb_q", {qa, qb}, 8'hcc);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
